// File: rtl/mem_preload_ctrl.sv
// Preload sequencer: parses header/payload words from a host link and drives
// the ICCM/DCCM write port, releasing the core once a FINISH header arrives.
module mem_preload_ctrl #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          iccm_we_o,
  output logic          dccm_we_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW-1:0] mem_wmask_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic          mem_finish_o,
  output logic          core_hold_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] OP_DCCM   = 2'b01;
  localparam logic [1:0] OP_FINISH = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  // Byte-enable nibble to a per-bit mask (bit i covers byte lane i).
  function automatic logic [DW-1:0] expand_mask(input logic [3:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          tgt_q, tgt_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          iccm_we_q, iccm_we_d;
  logic          dccm_we_q, dccm_we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] wmask_q, wmask_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          finish_q, hold_q, busy_q, err_q;
  logic          accept_s;

  logic [1:0] hdr_op_s;
  logic [3:0] hdr_rsvd_s;
  logic [3:0] hdr_be_s;

  assign accept_s   = s_valid_i && ready_q;
  assign hdr_op_s   = s_data_i[31:30];
  assign hdr_rsvd_s = s_data_i[29:26];
  assign hdr_be_s   = s_data_i[25:22];

  // Next-state and write-port datapath.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    iccm_we_d = 1'b0;
    dccm_we_d = 1'b0;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    waddr_d   = waddr_q;
    case (state_q)
      ST_HDR: begin
        if (!accept_s) begin
          state_d = ST_HDR;
        end else if (hdr_op_s == OP_ILL || hdr_rsvd_s != 4'd0) begin
          state_d = ST_ERR;
        end else if (hdr_op_s == OP_FINISH) begin
          state_d = ST_DONE;
        end else begin
          tgt_d   = (hdr_op_s == OP_DCCM);
          mask_d  = expand_mask(hdr_be_s);
          cnt_d   = s_data_i[11 +: AW];
          addr_d  = s_data_i[0 +: AW];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          iccm_we_d = ~tgt_q;
          dccm_we_d = tgt_q;
          wdata_d   = s_data_i;
          wmask_d   = mask_q;
          waddr_d   = addr_q;
          addr_d    = addr_q + AW'(1);
          cnt_d     = cnt_q - AW'(1);
          // Remaining count is stored as count-1, so zero marks the last word.
          if (cnt_q == '0) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
    ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_HDR;
      tgt_q     <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      iccm_we_q <= 1'b0;
      dccm_we_q <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      waddr_q   <= '0;
      finish_q  <= 1'b0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      iccm_we_q <= iccm_we_d;
      dccm_we_q <= dccm_we_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      waddr_q   <= waddr_d;
      finish_q  <= (state_d == ST_DONE);
      hold_q    <= (state_d != ST_DONE);
      busy_q    <= (state_d == ST_DATA);
      err_q     <= (state_d == ST_ERR);
    end
  end

  assign s_ready_o    = ready_q;
  assign iccm_we_o    = iccm_we_q;
  assign dccm_we_o    = dccm_we_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wmask_o  = wmask_q;
  assign mem_waddr_o  = waddr_q;
  assign mem_finish_o = finish_q;
  assign core_hold_o  = hold_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule
